// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - func codes and mul/div sequencer state encodings shared across EX
package mips_alu_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // MULT/MULTU/DIV/DIVU share the 0110xx prefix; the HI/LO moves share 0100xx.
    function automatic logic is_arith(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic logic is_hilo_op(input logic [5:0] f);
        return (f[5:2] == 4'b0110) || (f[5:2] == 4'b0100);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] op,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply: lo holds the unconsumed multiplier bits and fills with product bits from the top.
    // Divide: lo holds the dividend and fills with quotient bits from the bottom; hi is the remainder.
    always_comb begin
        mul_sum = {1'b0, hi_in} + {1'b0, (lo_in[0] ? op : {WIDTH{1'b0}})};
        shifted = {hi_in, lo_in[WIDTH-1]};
        fits    = shifted >= {1'b0, op};
        diff    = shifted[WIDTH-1:0] - op;
        hi_out  = mul_sum[WIDTH:1];
        lo_out  = {mul_sum[0], lo_in[WIDTH-1:1]};
        if (is_div) begin
            hi_out = fits ? diff : shifted[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - iterative MULT/DIV sequencer owning the HI/LO register pair
import mips_alu_pkg::*;

module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_op;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             is_div_q, neg_res_q, neg_a_q;

    logic             accept, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign busy   = (state != ST_IDLE);
    assign stall  = start && is_hilo_op(func) && busy;
    assign accept = start && is_arith(func) && (state == ST_IDLE);
    assign op_div = func[1];

    // Even func codes are the signed variants; unsigned ops take operands as-is.
    always_comb begin
        a_neg = ~func[0] & a[WIDTH-1];
        b_neg = ~func[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .hi_in  (r_hi),
        .lo_in  (r_lo),
        .op     (r_op),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    // A zero divisor magnitude means b was zero: hand back the dividend untouched.
    always_comb begin
        prod     = {r_hi, r_lo};
        prod_fix = neg_res_q ? -prod : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (r_op == '0) begin
                fix_hi = neg_a_q ? -r_lo : r_lo;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = neg_a_q ? -r_hi : r_hi;
                fix_lo = neg_res_q ? -r_lo : r_lo;
            end
        end
    end

    always_comb begin
        case (func)
            FN_MFHI: rd_data = hi;
            FN_MFLO: rd_data = lo;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (op_div && b == '0) ? ST_FIX : ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_op      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        r_hi      <= '0;
                        r_lo      <= op_div ? a_mag : b_mag;
                        r_op      <= op_div ? b_mag : a_mag;
                        is_div_q  <= op_div;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_a_q   <= a_neg;
                    end else if (start && func == FN_MTHI) begin
                        hi <= a;
                    end else if (start && func == FN_MTLO) begin
                        lo <= a;
                    end
                end
                ST_RUN: begin
                    r_hi <= step_hi;
                    r_lo <= step_lo;
                    cnt  <= cnt + 1'b1;
                end
                ST_FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
